// File: rtl/fir_unf_serializer.sv
// Output-side rate converter for the 3-parallel unfolded FIR.
// Buffers sample triples in a FIFO and re-emits them one sample per transfer.
module fir_unf_serializer #(
    parameter int NBIT  = 9,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VIN,
    input  logic [NBIT-1:0] DIN3k,
    input  logic [NBIT-1:0] DIN3k1,
    input  logic [NBIT-1:0] DIN3k2,
    output logic            RDY,
    output logic            OVF,
    input  logic            DREADY,
    output logic [NBIT-1:0] DOUT,
    output logic            VOUT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // One storage array per lane; a triple shares a single slot index.
    logic [NBIT-1:0] lane0_mem [DEPTH];
    logic [NBIT-1:0] lane1_mem [DEPTH];
    logic [NBIT-1:0] lane2_mem [DEPTH];

    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      sel;

    logic            push;
    logic            drop;
    logic            adv;
    logic            load;
    logic            pop;
    logic [NBIT-1:0] head;

    // Handshake decode; RDY looks only at registered count so a pop
    // in the same cycle never opens the input early.
    always_comb begin
        RDY  = (count < FULL) && !RST;
        push = VIN && RDY;
        drop = VIN && !RDY;
        adv  = !VOUT || DREADY;
        load = adv && (count != '0);
        pop  = load && (sel == 2'd2);
    end

    // Pick the lane of the head triple that goes out next.
    always_comb begin
        head = lane0_mem[rd_ptr];
        unique case (sel)
            2'd0:    head = lane0_mem[rd_ptr];
            2'd1:    head = lane1_mem[rd_ptr];
            default: head = lane2_mem[rd_ptr];
        endcase
    end

    // Triple storage; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            lane0_mem[wr_ptr] <= DIN3k;
            lane1_mem[wr_ptr] <= DIN3k1;
            lane2_mem[wr_ptr] <= DIN3k2;
        end
    end

    // Write pointer advances on every accepted triple, wrapping naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer advances when the last lane of the head is loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy in triples; the single source of full and empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Lane counter walks 0,1,2 across the head triple, one step per load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel <= 2'd0;
        end else if (load) begin
            if (sel == 2'd2) begin
                sel <= 2'd0;
            end else begin
                sel <= sel + 2'd1;
            end
        end
    end

    // Registered serial output; frozen while the sink stalls a valid sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= '0;
            VOUT <= 1'b0;
        end else if (load) begin
            DOUT <= head;
            VOUT <= 1'b1;
        end else if (adv) begin
            VOUT <= 1'b0;
        end
    end

    // Sticky overflow flag: a triple was offered while the FIFO was full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_unf_serializer.sv
// Directed self-checking bench for fir_unf_serializer.
// Linear stimulus with hand-computed expectations.
module tb_fir_unf_serializer;

    localparam int NBIT  = 9;
    localparam int DEPTH = 4;

    logic            CLK;
    logic            RST;
    logic            VIN;
    logic [NBIT-1:0] DIN3k;
    logic [NBIT-1:0] DIN3k1;
    logic [NBIT-1:0] DIN3k2;
    logic            RDY;
    logic            OVF;
    logic            DREADY;
    logic [NBIT-1:0] DOUT;
    logic            VOUT;

    int checks = 0;
    int errors = 0;

    fir_unf_serializer #(
        .NBIT  (NBIT),
        .DEPTH (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .VIN    (VIN),
        .DIN3k  (DIN3k),
        .DIN3k1 (DIN3k1),
        .DIN3k2 (DIN3k2),
        .RDY    (RDY),
        .OVF    (OVF),
        .DREADY (DREADY),
        .DOUT   (DOUT),
        .VOUT   (VOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] a,
                         input logic [8:0] b, input logic [8:0] c);
        VIN    = v;
        DIN3k  = a;
        DIN3k1 = b;
        DIN3k2 = c;
    endtask

    // {VOUT, DOUT} packed for compact output checks
    function automatic logic [31:0] vo(input logic v, input logic [8:0] d);
        return {22'd0, v, d};
    endfunction

    initial begin
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] c;
        int         out_idx;
        int         tnext;
        logic       rdy_low;

        RST    = 1'b1;
        DREADY = 1'b1;
        drive(1'b0, 9'h000, 9'h000, 9'h000);

        // ---- reset state ----
        #1;
        chk("rst_rdy_low", {31'd0, RDY}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_out", vo(VOUT, DOUT), vo(1'b0, 9'h000));
        chk("rst_rdy", {31'd0, RDY}, 32'd1);
        chk("rst_ovf", {31'd0, OVF}, 32'd0);

        // ---- single triple latency ----
        drive(1'b1, 9'h001, 9'h002, 9'h1FF);
        tick();
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        tick();
        chk("single_s0", vo(VOUT, DOUT), vo(1'b1, 9'h001));
        tick();
        chk("single_s1", vo(VOUT, DOUT), vo(1'b1, 9'h002));
        tick();
        chk("single_s2", vo(VOUT, DOUT), vo(1'b1, 9'h1FF));
        tick();
        chk("single_idle", {31'd0, VOUT}, 32'd0);

        // ---- continuous stream, one triple every 3 cycles ----
        rdy_low = 1'b0;
        for (int k = 0; k < 67; k++) begin
            a = 9'(3 * k);
            b = 9'(3 * k + 1);
            c = 9'(3 * k + 2);
            if (!RDY) rdy_low = 1'b1;
            drive(1'b1, a, b, c);
            tick();
            drive(1'b0, 9'h000, 9'h000, 9'h000);
            if (k > 0) chk("stream", vo(VOUT, DOUT), vo(1'b1, 9'(3 * k - 1)));
            if (!RDY) rdy_low = 1'b1;
            tick();
            chk("stream", vo(VOUT, DOUT), vo(1'b1, a));
            if (!RDY) rdy_low = 1'b1;
            tick();
            chk("stream", vo(VOUT, DOUT), vo(1'b1, b));
        end
        tick();
        chk("stream_last", vo(VOUT, DOUT), vo(1'b1, 9'd200));
        tick();
        chk("stream_idle", {31'd0, VOUT}, 32'd0);
        chk("stream_rdy", {31'd0, rdy_low}, 32'd0);
        chk("stream_ovf", {31'd0, OVF}, 32'd0);

        // ---- fill, overflow, drain ----
        DREADY = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 9'(9'h040 + 3 * t), 9'(9'h041 + 3 * t),
                  9'(9'h042 + 3 * t));
            tick();
        end
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        chk("full_rdy", {31'd0, RDY}, 32'd0);
        drive(1'b1, 9'h1EE, 9'h1ED, 9'h1EC);
        tick();
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        chk("ovf_set", {31'd0, OVF}, 32'd1);
        chk("full_head", vo(VOUT, DOUT), vo(1'b1, 9'h040));
        DREADY = 1'b1;
        for (int i = 1; i < 12; i++) begin
            tick();
            chk("drain", vo(VOUT, DOUT), vo(1'b1, 9'(9'h040 + i)));
            if (i == 1) chk("drain_rdy_lo", {31'd0, RDY}, 32'd0);
            if (i == 2) chk("drain_rdy_hi", {31'd0, RDY}, 32'd1);
        end
        tick();
        chk("drain_idle", {31'd0, VOUT}, 32'd0);
        chk("ovf_sticky", {31'd0, OVF}, 32'd1);

        // ---- stall on the middle lane ----
        drive(1'b1, 9'h031, 9'h032, 9'h033);
        tick();
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        tick();
        chk("stall_s0", vo(VOUT, DOUT), vo(1'b1, 9'h031));
        tick();
        chk("stall_s1", vo(VOUT, DOUT), vo(1'b1, 9'h032));
        DREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", vo(VOUT, DOUT), vo(1'b1, 9'h032));
        end
        DREADY = 1'b1;
        tick();
        chk("stall_s2", vo(VOUT, DOUT), vo(1'b1, 9'h033));
        tick();
        chk("stall_idle", vo(VOUT, DOUT), vo(1'b0, 9'h033));

        // ---- push and pop together at count=DEPTH-1, across wrap ----
        DREADY = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 9'(9'h080 + 3 * t), 9'(9'h081 + 3 * t),
                  9'(9'h082 + 3 * t));
            tick();
        end
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        chk("wrap_head", vo(VOUT, DOUT), vo(1'b1, 9'h080));
        DREADY  = 1'b1;
        out_idx = 1;
        tnext   = 3;
        for (int n = 4; out_idx < 36; n++) begin
            if (n >= 5 && ((n - 5) % 3) == 0 && tnext < 12) begin
                drive(1'b1, 9'(9'h080 + 3 * tnext), 9'(9'h081 + 3 * tnext),
                      9'(9'h082 + 3 * tnext));
                tnext++;
            end
            tick();
            drive(1'b0, 9'h000, 9'h000, 9'h000);
            chk("wrap_out", vo(VOUT, DOUT), vo(1'b1, 9'(9'h080 + out_idx)));
            chk("wrap_rdy", {31'd0, RDY}, 32'd1);
            out_idx++;
        end
        chk("wrap_pushes", tnext, 12);
        tick();
        chk("wrap_idle", {31'd0, VOUT}, 32'd0);

        // ---- reset in the middle of a triple ----
        drive(1'b1, 9'h011, 9'h012, 9'h013);
        tick();
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        tick();
        chk("mid_s0", vo(VOUT, DOUT), vo(1'b1, 9'h011));
        RST = 1'b1;
        #1;
        chk("mid_rst_rdy", {31'd0, RDY}, 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("mid_rst_out", vo(VOUT, DOUT), vo(1'b0, 9'h000));
        chk("mid_rst_rdy1", {31'd0, RDY}, 32'd1);
        chk("mid_rst_ovf", {31'd0, OVF}, 32'd0);
        tick();
        chk("mid_no_out", vo(VOUT, DOUT), vo(1'b0, 9'h000));
        drive(1'b1, 9'h0AA, 9'h155, 9'h100);
        tick();
        drive(1'b0, 9'h000, 9'h000, 9'h000);
        tick();
        chk("post_s0", vo(VOUT, DOUT), vo(1'b1, 9'h0AA));
        tick();
        chk("post_s1", vo(VOUT, DOUT), vo(1'b1, 9'h155));
        tick();
        chk("post_s2", vo(VOUT, DOUT), vo(1'b1, 9'h100));
        tick();
        chk("post_idle", {31'd0, VOUT}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
